// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: control inputs, ROM read port and decode handshake.
// master = fetch unit, slave = surrounding core / memory / decode.
interface instr_fetch_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  start;
   logic                  halt;
   logic                  br_valid;
   logic [ADDR_WIDTH-1:0] br_target;
   logic                  rom_rd_ena;
   logic [ADDR_WIDTH-1:0] rom_address;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  id_valid;
   logic                  id_ready;
   logic [DATA_WIDTH-1:0] id_instr;
   logic [ADDR_WIDTH-1:0] id_pc;
   logic                  busy;

   modport master (
      input  start, halt, br_valid, br_target, rom_data, id_ready,
      output rom_rd_ena, rom_address, id_valid, id_instr, id_pc, busy
   );

   modport slave (
      output start, halt, br_valid, br_target, rom_data, id_ready,
      input  rom_rd_ena, rom_address, id_valid, id_instr, id_pc, busy
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues ROM reads ahead of decode into a 2-entry
// {instr, pc} buffer, with redirect (branch) and permanent halt.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] fifo_instr_q [2];
   logic [DATA_WIDTH-1:0] fifo_instr_d [2];
   logic [ADDR_WIDTH-1:0] fifo_pc_q [2];
   logic [ADDR_WIDTH-1:0] fifo_pc_d [2];

   logic       run;
   logic       flush;
   logic       pop;
   logic       push;
   logic       issue;
   logic [2:0] occupancy;

   assign bus.id_valid    = (count_q != 2'd0);
   assign bus.id_instr    = fifo_instr_q[rd_ptr_q];
   assign bus.id_pc       = fifo_pc_q[rd_ptr_q];
   assign bus.rom_address = {2'b00, pc_q[ADDR_WIDTH-1:2]};
   assign bus.rom_rd_ena  = issue;
   assign bus.busy        = busy_q;

   always_comb begin
      run       = (state_q == S_RUN);
      flush     = run && (bus.halt || bus.br_valid);
      pop       = bus.id_valid && bus.id_ready;
      // Slots already committed after this cycle's pop; a new read needs one free.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue     = run && !bus.halt && !bus.br_valid && (occupancy < 3'd2);
      // Data returning in a redirect/halt cycle belongs to the abandoned path.
      push      = inflight_q && !flush;

      state_d       = state_q;
      pc_d          = pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
      fifo_instr_d  = fifo_instr_q;
      fifo_pc_d     = fifo_pc_q;

      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (bus.halt)  state_d = S_HALTED;
         default: state_d = state_q;
      endcase
      busy_d = (state_d == S_RUN);

      if (run && bus.halt) begin
         pc_d = pc_q;
      end else if (run && bus.br_valid) begin
         pc_d = {bus.br_target[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
         pc_d = pc_q + ADDR_WIDTH'(4);
      end

      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push && (wr_ptr_q == i[0])) begin
               fifo_instr_d[i] = bus.rom_data;
               fifo_pc_d[i]    = inflight_pc_q;
            end
         end
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         busy_q        <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         busy_q        <= busy_d;
         fifo_instr_q  <= fifo_instr_d;
         fifo_pc_q     <= fifo_pc_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM with mem[i]=0x100+i, program-order scoreboard
// fed by a stream model, directed scenarios followed by randomized traffic.
module tb_instr_fetch;
   localparam int              DW  = 32;
   localparam int              AW  = 32;
   localparam logic [AW-1:0]   RPC = 32'h0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   instr_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] waddr);
      return 32'h100 + waddr;
   endfunction

   initial bus.rom_data = '0;
   always @(posedge clk) begin
      if (bus.rom_rd_ena) bus.rom_data <= rom_word(bus.rom_address);
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the sequence decode must see is program order from the
   // last (re)start point; flushes simply restart that sequence.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;
   typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;

   txn_t        exp_q[$];
   logic [31:0] model_next_pc;
   mstate_t     mstate = M_IDLE;
   bit          flush_pending = 0;
   int          n_xfers = 0;

   task automatic refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back('{instr: rom_word(model_next_pc >> 2), pc: model_next_pc});
         model_next_pc = model_next_pc + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] a);
      exp_q.delete();
      model_next_pc = a;
      refill();
   endtask

   always @(negedge clk) begin
      txn_t e;
      if (!rst_n) begin
         mstate = M_IDLE;
         flush_pending = 0;
         exp_q.delete();
      end else begin
         check("busy", bus.busy, mstate == M_RUN);
         if (mstate != M_RUN) begin
            check("inactive_valid", bus.id_valid, 1'b0);
            check("inactive_rd_ena", bus.rom_rd_ena, 1'b0);
         end
         if (flush_pending) begin
            check("flush_valid", bus.id_valid, 1'b0);
            flush_pending = 0;
         end
         if (bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_xfer", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("xfer_instr", bus.id_instr, e.instr);
               check("xfer_pc", bus.id_pc, e.pc);
               n_xfers++;
               refill();
            end
         end
         if (mstate == M_IDLE && bus.start) begin
            mstate = M_RUN;
            restart_stream(RPC);
         end else if (mstate == M_RUN && bus.halt) begin
            mstate = M_HALT;
            exp_q.delete();
            flush_pending = 1;
         end else if (mstate == M_RUN && bus.br_valid) begin
            restart_stream({bus.br_target[31:2], 2'b00});
            flush_pending = 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_ena"}, bus.rom_rd_ena, 1'b0);
      check({tag, "_rom_addr"}, bus.rom_address, RPC >> 2);
      check({tag, "_id_valid"}, bus.id_valid, 1'b0);
      check({tag, "_id_instr"}, bus.id_instr, 32'h0);
      check({tag, "_id_pc"}, bus.id_pc, 32'h0);
      check({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   task automatic wait_first(input string name, input logic [31:0] exp_pc);
      bit found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (bus.id_valid && bus.id_ready) begin
            found = 1;
            check({name, "_instr"}, bus.id_instr, rom_word(exp_pc >> 2));
            check({name, "_pc"}, bus.id_pc, exp_pc);
         end
      end
      if (!found) check({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic branch(input logic [31:0] tgt);
      bus.br_valid = 1'b1;
      bus.br_target = tgt;
      @(negedge clk);
      check("br_cycle_rd_ena", bus.rom_rd_ena, 1'b0);
      cyc();
      bus.br_valid = 1'b0;
   endtask

   initial begin
      int xfers_before;
      bus.start = 0; bus.halt = 0; bus.br_valid = 0; bus.br_target = '0; bus.id_ready = 1;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");

      // Redirect while idle must be ignored.
      cyc(); bus.br_valid = 1; bus.br_target = 32'h80;
      cyc(); bus.br_valid = 0;
      repeat (2) cyc();

      // Start latency and first instructions.
      bus.start = 1;
      cyc(); bus.start = 0;
      @(negedge clk);
      check("t1_rd_ena", bus.rom_rd_ena, 1'b1);
      check("t1_valid", bus.id_valid, 1'b0);
      @(negedge clk);
      check("t2_valid", bus.id_valid, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("first_valid", bus.id_valid, 1'b1);
         check("first_instr", bus.id_instr, 32'h100 + k);
         check("first_pc", bus.id_pc, 4 * k);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("no_bubble", bus.id_valid, 1'b1);
      end

      // Decode stall: buffer fills and reads stop.
      cyc(); bus.id_ready = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_rd_ena", bus.rom_rd_ena, 1'b0);
         check("stall_valid", bus.id_valid, 1'b1);
      end
      cyc(); bus.id_ready = 1;
      repeat (6) cyc();

      branch(32'h40);
      wait_first("br40", 32'h40);
      repeat (4) cyc();
      branch(32'h43);
      wait_first("br43", 32'h40);
      repeat (2) cyc();
      branch(32'hFFFF_FFF8);
      repeat (8) cyc();

      for (int k = 0; k < 600; k++) begin
         bus.id_ready  = ($urandom % 4) != 0;
         bus.br_valid  = ($urandom % 20) == 0;
         bus.br_target = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 4096);
         cyc();
      end
      bus.br_valid = 0;

      // Reset with a full buffer discards everything.
      bus.id_ready = 0;
      repeat (4) cyc();
      rst_n = 0;
      cyc();
      rst_n = 1;
      @(negedge clk);
      check_reset_outputs("midreset");
      bus.id_ready = 1;
      repeat (4) cyc();
      bus.start = 1;
      cyc(); bus.start = 0;
      wait_first("restart", RPC);

      xfers_before = n_xfers;
      for (int k = 0; k < 600; k++) begin
         bus.id_ready  = ($urandom % 3) != 0;
         bus.br_valid  = ($urandom % 16) == 0;
         bus.br_target = $urandom % 8192;
         bus.start     = ($urandom % 8) == 0;
         cyc();
      end
      bus.br_valid = 0; bus.start = 0; bus.id_ready = 1;
      check("random_traffic", n_xfers > xfers_before + 100, 1'b1);
      repeat (4) cyc();

      // Halt together with redirect: halt wins, stop until reset.
      bus.halt = 1; bus.br_valid = 1; bus.br_target = 32'h40;
      cyc(); bus.halt = 0; bus.br_valid = 0;
      @(negedge clk);
      check("halt_valid", bus.id_valid, 1'b0);
      check("halt_rd_ena", bus.rom_rd_ena, 1'b0);
      check("halt_busy", bus.busy, 1'b0);
      bus.start = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("halt_start_ignored", bus.busy, 1'b0);
         check("halt_rd_stays_low", bus.rom_rd_ena, 1'b0);
      end
      bus.start = 0;
      repeat (2) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
